// File: rtl/tt_check_pkg.sv
// Shared state encoding, settle-counter width and row-count helper for the
// truth-table response checker.
package tt_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int SETTLE_W = 4;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each stimulus row is held
// before the response is sampled.
module tt_settle_timer
  import tt_check_pkg::*;
#(
  parameter int W = SETTLE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/tt_response_checker.sv
// Sweeps every input combination into a combinational device under check and
// compares its 1-bit response to EXPECTED. Optional macro TT_CAPTURE_EN adds
// the measured truth table as output "observed".
module tt_response_checker
  import tt_check_pkg::*;
#(
  parameter int                    N_IN     = 3,
  parameter logic [2**N_IN-1:0]    EXPECTED = 8'h2E,
  parameter int                    SETTLE   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic              resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_fail,
`ifdef TT_CAPTURE_EN
  output logic              fail_seen,
  output logic [2**N_IN-1:0] observed
`else
  output logic              fail_seen
`endif
);

  localparam int                  ROWS        = rows(N_IN);
  localparam logic [N_IN-1:0]     LAST_ROW    = N_IN'(ROWS - 1);
  localparam logic [N_IN:0]       ERR_MAX     = (N_IN + 1)'(ROWS);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

  state_t            state_reg, state_next;
  logic [N_IN-1:0]   stim_reg, stim_next;
  logic [N_IN:0]     err_reg, err_next;
  logic [N_IN-1:0]   first_fail_reg, first_fail_next;
  logic              fail_seen_reg, fail_seen_next;
  logic              timer_load, timer_zero, mismatch;
`ifdef TT_CAPTURE_EN
  logic [ROWS-1:0]   observed_reg, observed_next;
`endif

  tt_settle_timer #(.W(SETTLE_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (timer_load),
    .value (SETTLE_LOAD),
    .zero  (timer_zero)
  );

  // Case inequality makes an X/Z response count as a mismatch in simulation.
  assign mismatch = (resp !== EXPECTED[stim_reg]);

  always_comb begin
    state_next      = state_reg;
    stim_next       = stim_reg;
    err_next        = err_reg;
    first_fail_next = first_fail_reg;
    fail_seen_next  = fail_seen_reg;
    timer_load      = 1'b0;
`ifdef TT_CAPTURE_EN
    observed_next   = observed_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next      = ST_HOLD;
          stim_next       = '0;
          err_next        = '0;
          first_fail_next = '0;
          fail_seen_next  = 1'b0;
          timer_load      = 1'b1;
`ifdef TT_CAPTURE_EN
          observed_next   = '0;
`endif
        end
      end
      ST_HOLD: begin
        if (timer_zero) state_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          if (err_reg != ERR_MAX) err_next = err_reg + 1'b1;
          if (!fail_seen_reg) begin
            fail_seen_next  = 1'b1;
            first_fail_next = stim_reg;
          end
        end
`ifdef TT_CAPTURE_EN
        observed_next[stim_reg] = resp;
`endif
        if (stim_reg == LAST_ROW) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_HOLD;
          stim_next  = stim_reg + 1'b1;
          timer_load = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      stim_reg       <= '0;
      err_reg        <= '0;
      first_fail_reg <= '0;
      fail_seen_reg  <= 1'b0;
`ifdef TT_CAPTURE_EN
      observed_reg   <= '0;
`endif
    end else begin
      state_reg      <= state_next;
      stim_reg       <= stim_next;
      err_reg        <= err_next;
      first_fail_reg <= first_fail_next;
      fail_seen_reg  <= fail_seen_next;
`ifdef TT_CAPTURE_EN
      observed_reg   <= observed_next;
`endif
    end
  end

  assign stim       = stim_reg;
  assign busy       = (state_reg == ST_HOLD) || (state_reg == ST_SAMPLE);
  assign done       = (state_reg == ST_DONE);
  assign pass       = done && (err_reg == '0);
  assign err_count  = err_reg;
  assign first_fail = first_fail_reg;
  assign fail_seen  = fail_seen_reg;
`ifdef TT_CAPTURE_EN
  assign observed   = observed_reg;
`endif

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker: a 3-input and a 2-input instance,
// each driven by a selectable model of the device under check.
module tb_tt_response_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start3 = 1'b0, start2 = 1'b0;
  int         mode = 0;
  int         sel = 0;

  logic [2:0] stim3;
  logic       resp3, busy3, done3, pass3, fs3;
  logic [3:0] err3;
  logic [2:0] ff3;
  logic [1:0] stim2;
  logic       resp2, busy2, done2, pass2, fs2;
  logic [2:0] err2;
  logic [1:0] ff2;
`ifdef TT_CAPTURE_EN
  logic [7:0] obs3;
  logic [3:0] obs2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // DUC models: f = b ? ~a : c with {a,b,c} = stim, and a 2-input XNOR.
  logic f3, x2;
  assign f3 = stim3[1] ? ~stim3[2] : stim3[0];
  assign x2 = ~(stim2[1] ^ stim2[0]);
  assign resp3 = (mode == 0) ? f3 : (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : ~f3;
  assign resp2 = (mode == 0) ? x2 : (mode == 1) ? ~x2 : 1'b1;

  tt_response_checker dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .stim(stim3), .resp(resp3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .first_fail(ff3),
`ifdef TT_CAPTURE_EN
    .fail_seen(fs3), .observed(obs3)
`else
    .fail_seen(fs3)
`endif
  );

  tt_response_checker #(.N_IN(2), .EXPECTED(4'b1001), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2), .resp(resp2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_fail(ff2),
`ifdef TT_CAPTURE_EN
    .fail_seen(fs2), .observed(obs2)
`else
    .fail_seen(fs2)
`endif
  );

  // Views of whichever instance is selected.
  logic       m_done, m_busy, m_pass, m_fs;
  logic [2:0] m_stim, m_ff;
  logic [3:0] m_err;
  assign m_done = sel ? done2 : done3;
  assign m_busy = sel ? busy2 : busy3;
  assign m_pass = sel ? pass2 : pass3;
  assign m_fs   = sel ? fs2 : fs3;
  assign m_stim = sel ? {1'b0, stim2} : stim3;
  assign m_ff   = sel ? {1'b0, ff2} : ff3;
  assign m_err  = sel ? {1'b0, err2} : err3;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Pulses start, then counts rising edges from the one sampling start until
  // done is seen; meanwhile checks stim = k/3 after edge k, busy=1 and pass=0.
  task automatic run_sweep(output int lat, output int bad);
    lat = 0;
    bad = 0;
    @(negedge clk);
    if (sel != 0) start2 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start3 = 1'b0;
    lat = 1;
    while (!m_done && lat < 200) begin
      if (int'(m_stim) != (lat - 1) / 3) bad++;
      if (!m_busy || m_pass) bad++;
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    string name;
    int    sel;
    int    mode;
    int    lat;
    int    pass;
    int    err;
    int    ff;
    int    fs;
  } vec_t;

  vec_t vecs[7];
  int   lat, bad, pulsed;

  initial begin
    vecs[0] = '{"n3_exact",   0, 0, 25, 1, 0, 0, 0};
    vecs[1] = '{"n3_const0",  0, 1, 25, 0, 4, 1, 1};
    vecs[2] = '{"n3_const1",  0, 2, 25, 0, 4, 0, 1};
    vecs[3] = '{"n3_inverted",0, 3, 25, 0, 8, 0, 1};
    vecs[4] = '{"n2_xnor",    1, 0, 13, 1, 0, 0, 0};
    vecs[5] = '{"n2_xor",     1, 1, 13, 0, 4, 0, 1};
    vecs[6] = '{"n2_const1",  1, 2, 13, 0, 2, 1, 1};

    // Reset state while rst_n is low.
    #2;
    check("rst_stim3", int'(stim3), 0);
    check("rst_busy3", int'(busy3), 0);
    check("rst_done3", int'(done3), 0);
    check("rst_pass3", int'(pass3), 0);
    check("rst_err3",  int'(err3), 0);
    check("rst_ff3",   int'(ff3), 0);
    check("rst_fs3",   int'(fs3), 0);
    check("rst_busy2", int'(busy2), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy3", int'(busy3), 0);

    for (int i = 0; i < 7; i++) begin
      sel  = vecs[i].sel;
      mode = vecs[i].mode;
      run_sweep(lat, bad);
      $display("vector %s: lat=%0d pass=%0d err=%0d first_fail=%0d fail_seen=%0d",
               vecs[i].name, lat, m_pass, m_err, m_ff, m_fs);
      check({vecs[i].name, "_lat"},  lat, vecs[i].lat);
      check({vecs[i].name, "_seq"},  bad, 0);
      check({vecs[i].name, "_pass"}, int'(m_pass), vecs[i].pass);
      check({vecs[i].name, "_err"},  int'(m_err), vecs[i].err);
      check({vecs[i].name, "_ff"},   int'(m_ff), vecs[i].ff);
      check({vecs[i].name, "_fs"},   int'(m_fs), vecs[i].fs);
      check({vecs[i].name, "_busy"}, int'(m_busy), 0);
`ifdef TT_CAPTURE_EN
      if (i == 2) check("n3_const1_observed", int'(obs3), 255);
`endif
    end

    // start pulsed during the HOLD of row 3 must be ignored.
    sel = 0;
    mode = 0;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 1;
    pulsed = 0;
    while (!done3 && lat < 200) begin
      if (pulsed == 0 && stim3 == 3'd3) begin
        start3 = 1'b1;
        pulsed = 1;
      end else begin
        start3 = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start3 = 1'b0;
    $display("restart-ignored sweep: lat=%0d pass=%0d", lat, pass3);
    check("ignore_lat", lat, 25);
    check("ignore_pass", int'(pass3), 1);

    // start in DONE clears the previous result and begins a sweep at once.
    mode = 1;
    run_sweep(lat, bad);
    check("redo_first_err", int'(err3), 4);
    mode = 0;
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    $display("start in DONE: busy=%0d done=%0d err=%0d fs=%0d stim=%0d",
             busy3, done3, err3, fs3, stim3);
    check("redo_busy", int'(busy3), 1);
    check("redo_done", int'(done3), 0);
    check("redo_err",  int'(err3), 0);
    check("redo_fs",   int'(fs3), 0);
    check("redo_ff",   int'(ff3), 0);
    check("redo_stim", int'(stim3), 0);
    lat = 1;
    while (!done3 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("redo_lat", lat, 25);
    check("redo_pass", int'(pass3), 1);

    // Asynchronous reset during the SAMPLE cycle of row 4.
    mode = 1;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    lat = 0;
    while (stim3 != 3'd4 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("reach_row4", int'(lat < 200), 1);
    repeat (2) @(negedge clk);
    check("pre_rst_err", int'(err3), 3);
    #2 rst_n = 1'b0;
    #1;
    $display("mid-sample reset: stim=%0d busy=%0d err=%0d", stim3, busy3, err3);
    check("arst_stim", int'(stim3), 0);
    check("arst_busy", int'(busy3), 0);
    check("arst_err",  int'(err3), 0);
    check("arst_fs",   int'(fs3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_busy", int'(busy3), 0);
    check("post_rst_done", int'(done3), 0);
    check("post_rst_stim", int'(stim3), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
